// File: rtl/eq_pkg.sv
// Shared equalizer-chain constants plus band slicing and saturating magnitude helpers.
package eq_pkg;

  localparam int unsigned NUMBER_OF_FILTERS = 8;
  localparam int unsigned FILTER_OUT_BITS   = 16;
  localparam int unsigned LEVEL_BITS        = FILTER_OUT_BITS - 1;

  // LSB position of a band inside the packed sample bus
  function automatic int unsigned band_lsb(input int unsigned band);
    return band * FILTER_OUT_BITS;
  endfunction

  // LSB position of a band inside the packed level bus
  function automatic int unsigned level_lsb(input int unsigned band);
    return band * LEVEL_BITS;
  endfunction

  // |x| clipped to LEVEL_BITS; the single unrepresentable case (most negative) saturates
  function automatic logic [LEVEL_BITS-1:0] sat_abs(input logic [FILTER_OUT_BITS-1:0] x);
    logic [FILTER_OUT_BITS-1:0] mag;
    mag = x[FILTER_OUT_BITS-1] ? -x : x;
    if (mag[FILTER_OUT_BITS-1]) begin
      return '1;
    end
    return mag[LEVEL_BITS-1:0];
  endfunction

endpackage

// File: rtl/band_level_meter_if.sv
// Sample-in / level-out bundle between the filter bank side and the level meter.
interface band_level_meter_if;
  import eq_pkg::*;

  logic                                         clk_enable;
  logic                                         sample_valid;
  logic                                         clear;
  logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] band_samples;
  logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0]      levels;
  logic                                         levels_valid;
  logic [NUMBER_OF_FILTERS-1:0]                 clip_flags;

  modport master (
    output clk_enable, sample_valid, clear, band_samples,
    input  levels, levels_valid, clip_flags
  );

  modport slave (
    input  clk_enable, sample_valid, clear, band_samples,
    output levels, levels_valid, clip_flags
  );

endinterface

// File: rtl/band_peak_tracker.sv
// Single-band peak tracker: saturating magnitude, peak hold, linear decay and sticky clip.
module band_peak_tracker
  import eq_pkg::*;
#(
  parameter int unsigned HOLD_SAMPLES = 1024,
  parameter int unsigned DECAY_STEP   = 16,
  parameter int unsigned CLIP_LEVEL   = 32000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update,
  input  logic                       clear,
  input  logic [FILTER_OUT_BITS-1:0] sample,
  output logic [LEVEL_BITS-1:0]      level,
  output logic                       clip
);

  localparam int unsigned HOLD_BITS = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_BITS-1:0]  HOLD_LOAD = HOLD_BITS'(HOLD_SAMPLES);
  localparam logic [HOLD_BITS-1:0]  HOLD_ONE  = HOLD_BITS'(1);
  localparam logic [LEVEL_BITS-1:0] STEP      = LEVEL_BITS'(DECAY_STEP);
  localparam logic [LEVEL_BITS-1:0] CLIP_TH   = LEVEL_BITS'(CLIP_LEVEL);

  logic [LEVEL_BITS-1:0] mag;
  logic [LEVEL_BITS-1:0] level_next;
  logic [HOLD_BITS-1:0]  hold, hold_next;
  logic                  clip_next;

  assign mag = sat_abs(sample);

  always_comb begin
    level_next = level;
    hold_next  = hold;
    clip_next  = clip;
    if (clear) begin
      level_next = '0;
      hold_next  = '0;
      clip_next  = 1'b0;
    end else if (update) begin
      if (mag >= level) begin
        level_next = mag;
        hold_next  = HOLD_LOAD;
      end else if (hold != '0) begin
        hold_next = hold - HOLD_ONE;
      end else begin
        // floor at zero rather than wrapping when the level is within one step
        level_next = (level > STEP) ? level - STEP : '0;
      end
      if (mag >= CLIP_TH) begin
        clip_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      hold  <= '0;
      clip  <= 1'b0;
    end else begin
      level <= level_next;
      hold  <= hold_next;
      clip  <= clip_next;
    end
  end

endmodule

// File: rtl/band_level_meter.sv
// Per-band peak-level meter fed by the equalizer filter bank; drives UI readout and gain control.
module band_level_meter
  import eq_pkg::*;
#(
  parameter int unsigned HOLD_SAMPLES = 1024,
  parameter int unsigned DECAY_STEP   = 16,
  parameter int unsigned CLIP_LEVEL   = 32000
) (
  input  logic               clk,
  input  logic               rst,
  band_level_meter_if.slave  bus
);

  logic                                    update;
  logic                                    flush;
  logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0] levels_packed;
  logic [NUMBER_OF_FILTERS-1:0]            clip_vec;
  logic                                    levels_valid_q;

  // clear wins over a coincident sample; a disabled clock blocks both
  assign update = bus.clk_enable & bus.sample_valid & ~bus.clear;
  assign flush  = bus.clk_enable & bus.clear;

  for (genvar i = 0; i < NUMBER_OF_FILTERS; i++) begin : g_band
    band_peak_tracker #(
      .HOLD_SAMPLES (HOLD_SAMPLES),
      .DECAY_STEP   (DECAY_STEP),
      .CLIP_LEVEL   (CLIP_LEVEL)
    ) u_tracker (
      .clk    (clk),
      .rst    (rst),
      .update (update),
      .clear  (flush),
      .sample (bus.band_samples[band_lsb(i) +: FILTER_OUT_BITS]),
      .level  (levels_packed[level_lsb(i) +: LEVEL_BITS]),
      .clip   (clip_vec[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      levels_valid_q <= 1'b0;
    end else begin
      levels_valid_q <= update;
    end
  end

  assign bus.levels       = levels_packed;
  assign bus.clip_flags   = clip_vec;
  assign bus.levels_valid = levels_valid_q;

endmodule

// File: tb/tb_band_level_meter.sv
// Scoreboard bench for band_level_meter with short hold/decay settings and hand-computed levels.
module tb_band_level_meter;
  import eq_pkg::*;

  typedef struct {
    logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0] lv;
    logic [NUMBER_OF_FILTERS-1:0]            cf;
    string                                   tag;
  } exp_t;

  logic clk;
  logic rst;
  band_level_meter_if bus ();

  band_level_meter #(
    .HOLD_SAMPLES (2),
    .DECAY_STEP   (100),
    .CLIP_LEVEL   (32000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0] lvs(input int b0, input int b1,
                                                                  input int b2, input int b3);
    logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0] r;
    r = '0;
    r[0*LEVEL_BITS +: LEVEL_BITS] = LEVEL_BITS'(b0);
    r[1*LEVEL_BITS +: LEVEL_BITS] = LEVEL_BITS'(b1);
    r[2*LEVEL_BITS +: LEVEL_BITS] = LEVEL_BITS'(b2);
    r[3*LEVEL_BITS +: LEVEL_BITS] = LEVEL_BITS'(b3);
    return r;
  endfunction

  function automatic logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] smp(input int s0, input int s1,
                                                                       input int s2, input int s3);
    logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] r;
    r = '0;
    r[0*FILTER_OUT_BITS +: FILTER_OUT_BITS] = FILTER_OUT_BITS'(s0);
    r[1*FILTER_OUT_BITS +: FILTER_OUT_BITS] = FILTER_OUT_BITS'(s1);
    r[2*FILTER_OUT_BITS +: FILTER_OUT_BITS] = FILTER_OUT_BITS'(s2);
    r[3*FILTER_OUT_BITS +: FILTER_OUT_BITS] = FILTER_OUT_BITS'(s3);
    return r;
  endfunction

  task automatic check_state(input string tag,
                             input logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0] elv,
                             input logic [NUMBER_OF_FILTERS-1:0] ecf, input logic evalid);
    n_cmp++;
    if (bus.levels !== elv || bus.clip_flags !== ecf || bus.levels_valid !== evalid) begin
      n_fail++;
      $display("FAIL %s: levels=%h clip=%h valid=%b, expected levels=%h clip=%h valid=%b",
               tag, bus.levels, bus.clip_flags, bus.levels_valid, elv, ecf, evalid);
    end
  endtask

  task automatic send(input logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] s,
                      input logic [NUMBER_OF_FILTERS*LEVEL_BITS-1:0] elv,
                      input logic [NUMBER_OF_FILTERS-1:0] ecf, input string tag);
    exp_t e;
    e.lv = elv;
    e.cf = ecf;
    e.tag = tag;
    q.push_back(e);
    bus.band_samples = s;
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  // Monitor: every levels_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.levels_valid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: levels=%h clip=%h, expected no levels_valid pulse",
                 bus.levels, bus.clip_flags);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.levels !== e.lv || bus.clip_flags !== e.cf) begin
          n_fail++;
          $display("FAIL %s: levels=%h clip=%h, expected levels=%h clip=%h",
                   e.tag, bus.levels, bus.clip_flags, e.lv, e.cf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.clk_enable   = 1'b1;
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    bus.band_samples = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_state", '0, '0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(smp(1000, 0, 0, 0), lvs(1000, 0, 0, 0), 8'h00, "first_peak");
    send(smp(0, 0, 0, 0),    lvs(1000, 0, 0, 0), 8'h00, "hold_1");
    send(smp(0, 0, 0, 0),    lvs(1000, 0, 0, 0), 8'h00, "hold_2");
    send(smp(0, 0, 0, 0),    lvs(900, 0, 0, 0),  8'h00, "decay_1");
    send(smp(0, 0, 0, 0),    lvs(800, 0, 0, 0),  8'h00, "decay_2");

    send(smp(0, 0, 0, -32768), lvs(700, 0, 0, 32767), 8'h08, "neg_full_scale");
    send(smp(0, 0, 0, 0),      lvs(600, 0, 0, 32767), 8'h08, "clip_sticky_1");
    send(smp(0, 0, 0, 0),      lvs(500, 0, 0, 32767), 8'h08, "clip_sticky_2");

    bus.clear = 1'b1;
    bus.band_samples = smp(5000, 0, 0, 0);
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.sample_valid = 1'b0;
    check_state("clear_over_sample", '0, '0, 1'b0);

    send(smp(200, 0, 0, 0),   lvs(200, 0, 0, 0),     8'h00, "after_clear");
    send(smp(0, 0, 0, 31999), lvs(200, 0, 0, 31999), 8'h00, "below_clip");

    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    check_state("clear_alone", '0, '0, 1'b0);

    send(smp(50, 0, 0, 0), lvs(50, 0, 0, 0), 8'h00, "small_peak");
    send(smp(0, 0, 0, 0),  lvs(50, 0, 0, 0), 8'h00, "small_hold_1");
    send(smp(0, 0, 0, 0),  lvs(50, 0, 0, 0), 8'h00, "small_hold_2");
    send(smp(0, 0, 0, 0),  lvs(0, 0, 0, 0),  8'h00, "decay_floor");
    send(smp(0, 0, 0, 0),  lvs(0, 0, 0, 0),  8'h00, "floor_stays");

    send(smp(0, 3000, 0, 0), lvs(0, 3000, 0, 0), 8'h00, "band1_peak");
    bus.clk_enable = 1'b0;
    bus.band_samples = smp(0, 9000, 0, 0);
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    check_state("disabled_ignore", lvs(0, 3000, 0, 0), 8'h00, 1'b0);
    bus.clk_enable = 1'b1;
    send(smp(0, 9000, 0, 0), lvs(0, 9000, 0, 0), 8'h00, "reenabled");

    send(smp(0, 0, 20000, 0), lvs(0, 9000, 20000, 0), 8'h00, "band2_peak");
    send(smp(0, 0, 0, 0),     lvs(0, 9000, 20000, 0), 8'h00, "band2_hold");

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_reset_mid_hold", '0, '0, 1'b0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(smp(0, -7, 10, 0), lvs(0, 7, 10, 0), 8'h00, "post_reset_sample");

    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected updates never appeared, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/band_level_meter.md
Name: band_level_meter

Overview:
- Per-band peak-level meter that sits directly downstream of the 8-band equalizer filter bank.
- Consumes the packed band outputs once per output sample and tracks a peak magnitude per band, with a hold time and linear decay.
- Raises a sticky clip flag per band.
- Levels drive the front-panel/UI readout and the gain-control logic; the block is read-only with respect to the audio path.

Parameters:
- NUMBER_OF_FILTERS, 8, number of bands.
- FILTER_OUT_BITS, 16, width of each signed band sample.
- LEVEL_BITS, FILTER_OUT_BITS-1, unsigned magnitude width (15).
- HOLD_SAMPLES, 1024, samples a new peak is held before decay starts.
- HOLD_BITS, $clog2(HOLD_SAMPLES+1), hold counter width.
- DECAY_STEP, 16, magnitude subtracted per sample once hold expires.
- CLIP_LEVEL, 32000, magnitude at or above which the clip flag sets.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clk_enable  input  1  global clock enable; all state frozen when low.
- sample_valid  input  1  one-cycle strobe: band_samples holds a new sample set.
- clear  input  1  synchronous clear of levels, hold counters and clip flags.
- band_samples  input  NUMBER_OF_FILTERS*FILTER_OUT_BITS  packed signed band samples; band i at [(i+1)*FILTER_OUT_BITS-1 : i*FILTER_OUT_BITS].
- levels  output  NUMBER_OF_FILTERS*LEVEL_BITS  packed unsigned peak levels, same packing order.
- levels_valid  output  1  one-cycle pulse: levels were updated.
- clip_flags  output  NUMBER_OF_FILTERS  sticky per-band clip indicators.

Behaviour:
- Reset (async, rst=1):
  - levels=0, clip_flags=0, levels_valid=0.
  - All hold counters=0.
  - Applies immediately regardless of clk_enable, including mid-hold or mid-decay.
- Magnitude:
  - mag = |x|, LEVEL_BITS wide.
  - x = -2^(FILTER_OUT_BITS-1) saturates to 2^LEVEL_BITS-1 (-32768 -> 32767).
  - No wrap.
- Update condition U = clk_enable & sample_valid & ~clear. On U, per band, independently:
  - if mag >= level: level <= mag; hold <= HOLD_SAMPLES.
  - else if hold != 0: hold <= hold-1; level unchanged.
  - else level <= (level > DECAY_STEP) ? level-DECAY_STEP : 0. Floors at 0, never underflows.
  - if mag >= CLIP_LEVEL: clip_flag <= 1. Sticky until clear or rst.
- Latency:
  - levels and clip_flags are registered and reflect a sample on the cycle after its sample_valid.
  - levels_valid <= U, so it pulses the same cycle the new levels appear.
- clear:
  - Applied when clk_enable=1.
  - Zeros levels, hold counters and clip_flags.
  - levels_valid=0 that cycle.
  - Takes priority over a simultaneous sample_valid; that sample is dropped.
- clk_enable=0:
  - No state change; a sample_valid arriving in that cycle is ignored.
  - levels_valid <= 0.
- Back-to-back sample_valid on consecutive cycles is legal; each is processed.
- Hold expiry: with HOLD_SAMPLES=N, a peak stays constant for the N following lower samples; the first decay occurs on the (N+1)th.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package eq_pkg holds:
  - constants NUMBER_OF_FILTERS, FILTER_OUT_BITS, LEVEL_BITS;
  - band packing/slice helper (index -> bit range);
  - the saturating-abs function, reused by the amplifier/limiter stages.
- One sub-module band_peak_tracker: single-band mag/hold/decay/clip logic.
  - Generated NUMBER_OF_FILTERS times.
  - Top level owns levels_valid, clear gating and packing.

Test Plan:
- rst pulse, then band0=1000, others 0, one sample_valid -> next cycle level0=1000, other levels 0, levels_valid pulses 1 cycle, clip_flags=0.
- HOLD_SAMPLES=2, DECAY_STEP=100: peak 1000, then samples of 0 -> level0 reads 1000, 1000, 900, 800, ...; level 50 with step 100 -> 0 and stays 0.
- band3=-32768 -> level3=32767, clip_flags[3]=1; later samples of 0 -> clip_flags[3] stays 1 until clear; band3=31999 alone never sets it.
- clear and sample_valid (band0=5000) in the same cycle -> levels=0, clip_flags=0, levels_valid=0; next sample band0=200 -> level0=200.
- clk_enable=0 while sample_valid pulses with band1=9000 -> no change, no levels_valid; re-enable -> next sample updates normally.
- rst asserted mid-hold (level2=20000, hold=500) -> outputs 0 asynchronously, before the next clk edge; after release, first sample 10 -> level2=10.
